// File: rtl/z80_vram_bridge.sv
// ---------------------------------------------------------------------------
// z80_vram_bridge
//
// Purpose:
//   Upstream stage of the character video generator. Turns Z80 memory cycles
//   that hit the 2 KB video-RAM window into single-cycle port-1 strobes
//   (rd_ram1 / wr_ram1 with addr / data), returns read data from ram1_out to
//   the CPU and stretches reads with WAIT# until the data is present.
//   Runs in the 25 MHz pixel domain; the CPU strobes are synchronised here.
//
// Optional feature:
//   `CPU_SYNC_BYPASS_EN  - when defined, the strobe synchronisers are a single
//                          register stage (CPU clocked from clk through a clock
//                          enable), so every latency shrinks by one cycle.
//
// Parameters:
//   VRAM_BASE  - CPU base address of the video window, bits [10:0] zero
//   WAIT_EN    - 1: pull cpu_wait_n low while a read is in flight
//                0: cpu_wait_n is held high
//
// Ports:
//   clk         in   25 MHz pixel clock
//   resetn      in   synchronous, active-low reset
//   cpu_addr    in   [15:0] Z80 address bus
//   cpu_dout    in   [7:0]  data driven by the CPU on writes
//   cpu_mreq_n  in   Z80 MREQ#
//   cpu_rd_n    in   Z80 RD#
//   cpu_wr_n    in   Z80 WR#
//   cpu_din     out  [7:0]  read data to the CPU
//   cpu_doe     out  bridge drives cpu_din onto the CPU bus
//   cpu_wait_n  out  Z80 WAIT#
//   rd_ram1     out  video RAM read strobe, one cycle
//   wr_ram1     out  video RAM write strobe, one cycle
//   addr        out  [10:0] video RAM address
//   data        out  [7:0]  video RAM write data
//   ram1_out    in   [7:0]  video RAM read data, valid 1 cycle after rd_ram1
// ---------------------------------------------------------------------------
module z80_vram_bridge #(
    parameter logic [15:0] VRAM_BASE = 16'h2800,
    parameter logic        WAIT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_doe,
    output logic        cpu_wait_n,
    output logic        rd_ram1,
    output logic        wr_ram1,
    output logic [10:0] addr,
    output logic [7:0]  data,
    input  logic [7:0]  ram1_out
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPT,
        HOLD
    } state_t;

    state_t state;
    state_t state_d;

    logic mreq_s;
    logic rd_s;
    logic wr_s;

    // Strobe synchronisers. They reset to 1 so a CPU that is still mid-cycle
    // when reset releases is seen as a fresh request rather than a stale one.
`ifdef CPU_SYNC_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mreq_s <= 1'b1;
            rd_s   <= 1'b1;
            wr_s   <= 1'b1;
        end else begin
            mreq_s <= cpu_mreq_n;
            rd_s   <= cpu_rd_n;
            wr_s   <= cpu_wr_n;
        end
    end
`else
    logic [1:0] mreq_sync;
    logic [1:0] rd_sync;
    logic [1:0] wr_sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mreq_sync <= 2'b11;
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
        end else begin
            mreq_sync <= {mreq_sync[0], cpu_mreq_n};
            rd_sync   <= {rd_sync[0], cpu_rd_n};
            wr_sync   <= {wr_sync[0], cpu_wr_n};
        end
    end

    assign mreq_s = mreq_sync[1];
    assign rd_s   = rd_sync[1];
    assign wr_s   = wr_sync[1];
`endif

    logic hit;
    logic request;

    // Address is taken straight from the bus: the Z80 holds it stable for
    // the whole time the strobes are low, so it needs no synchroniser.
    assign hit     = (cpu_addr[15:11] == VRAM_BASE[15:11]);
    assign request = !mreq_s && (!rd_s || !wr_s);

    logic latch_addr;
    logic latch_data;
    logic capture;
    logic release_bus;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. Every access ends in HOLD, which waits for MREQ#
    // to go high, so a long CPU cycle produces exactly one strobe.
    always_comb begin
        state_d     = state;
        latch_addr  = 1'b0;
        latch_data  = 1'b0;
        capture     = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (!hit) begin
                        state_d = HOLD;
                    end else if (!wr_s) begin
                        state_d    = WR;
                        latch_addr = 1'b1;
                        latch_data = 1'b1;
                    end else begin
                        state_d    = RD_ISSUE;
                        latch_addr = 1'b1;
                    end
                end
            end
            WR: begin
                state_d = HOLD;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // rd_ram1 is registered, so it is high during the first
                // RD_WAIT cycle; once it has dropped, ram1_out holds the data.
                if (!rd_ram1) begin
                    state_d = RD_CAPT;
                    capture = 1'b1;
                end
            end
            RD_CAPT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (mreq_s) begin
                    state_d     = IDLE;
                    release_bus = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs. The strobes follow the state by one cycle, and
    // WAIT# is driven from the next state so that it is low for exactly the
    // cycles between the read strobe and the data being captured.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ram1    <= 1'b0;
            wr_ram1    <= 1'b0;
            addr       <= 11'd0;
            data       <= 8'd0;
            cpu_din    <= 8'd0;
            cpu_doe    <= 1'b0;
            cpu_wait_n <= 1'b1;
        end else begin
            wr_ram1 <= (state == WR);
            rd_ram1 <= (state == RD_ISSUE);
            if (WAIT_EN) begin
                cpu_wait_n <= (state_d != RD_WAIT);
            end else begin
                cpu_wait_n <= 1'b1;
            end
            if (latch_addr) begin
                addr <= cpu_addr[10:0];
            end
            if (latch_data) begin
                data <= cpu_dout;
            end
            if (capture) begin
                cpu_din <= ram1_out;
                cpu_doe <= 1'b1;
            end else if (release_bus) begin
                cpu_doe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_z80_vram_bridge.sv
// ---------------------------------------------------------------------------
// tb_z80_vram_bridge
//
// Purpose:
//   Self-checking bench for z80_vram_bridge. Stimulus tasks drive Z80 memory
//   cycles and push the expected port-1 events (write strobe, read strobe,
//   returned data) with their expected cycle into a scoreboard queue; a
//   monitor on the falling edge pops and compares whenever the DUT presents
//   a strobe or raises cpu_doe. A small video RAM model answers reads.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_z80_vram_bridge;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_DIN = 2;

`ifdef CPU_SYNC_BYPASS_EN
    localparam int LAT_STB = 3;
    localparam int LAT_DIN = 5;
`else
    localparam int LAT_STB = 4;
    localparam int LAT_DIN = 6;
`endif

    typedef struct {
        int          kind;
        logic [10:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_din;
    logic        cpu_doe;
    logic        cpu_wait_n;
    logic        rd_ram1;
    logic        wr_ram1;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [7:0]  ram1_out;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   cycle;
    int   wait_low_cycles;
    logic doe_prev;
    logic [7:0] vram [0:2047];

    z80_vram_bridge #(
        .VRAM_BASE (16'h2800),
        .WAIT_EN   (1'b1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_din    (cpu_din),
        .cpu_doe    (cpu_doe),
        .cpu_wait_n (cpu_wait_n),
        .rd_ram1    (rd_ram1),
        .wr_ram1    (wr_ram1),
        .addr       (addr),
        .data       (data),
        .ram1_out   (ram1_out)
    );

    // 25 MHz-style clock, period 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycle = cycle + 1;
    end

    // Video RAM model: write on the strobe, read data valid one cycle later.
    always @(posedge clk) begin
        if (wr_ram1) begin
            vram[addr] <= data;
        end
        if (rd_ram1) begin
            ram1_out <= vram[addr];
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic popAndCheck(input int kind, input logic [10:0] a, input logic [7:0] d);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL unexpected_event kind=%0d actual_addr=%0h actual_data=%0h required=none (cycle %0d)",
                     kind, a, d, cycle);
        end else begin
            e = sb_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (e.kind != K_DIN) checkOutput("strobe_addr", int'(a), int'(e.addr));
            if (e.kind != K_RD)  checkOutput("event_data", int'(d), int'(e.data));
            checkOutput("event_cycle", cycle, e.cyc);
        end
    endtask

    // Monitor: compare every strobe and every rising cpu_doe against the
    // scoreboard, and count cycles with WAIT# low.
    always @(negedge clk) begin
        if (!cpu_wait_n) wait_low_cycles = wait_low_cycles + 1;
        if (wr_ram1) popAndCheck(K_WR, addr, data);
        if (rd_ram1) popAndCheck(K_RD, addr, 8'h00);
        if (cpu_doe && !doe_prev) popAndCheck(K_DIN, 11'h000, cpu_din);
        doe_prev = cpu_doe;
    end

    task automatic pushExp(input int kind, input logic [10:0] a, input logic [7:0] d, input int cyc);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_ram1"},    int'(rd_ram1),    0);
        checkOutput({tag, "_wr_ram1"},    int'(wr_ram1),    0);
        checkOutput({tag, "_addr"},       int'(addr),       0);
        checkOutput({tag, "_data"},       int'(data),       0);
        checkOutput({tag, "_cpu_din"},    int'(cpu_din),    0);
        checkOutput({tag, "_cpu_doe"},    int'(cpu_doe),    0);
        checkOutput({tag, "_cpu_wait_n"}, int'(cpu_wait_n), 1);
    endtask

    // One Z80 memory cycle held for 'hold' clocks. exp_hit/exp_din are the
    // hand-worked expectations for this vector.
    task automatic applyStimulus(input logic [15:0] a, input logic w, input logic r,
                                 input logic [7:0] d, input int hold,
                                 input logic exp_hit, input logic [7:0] exp_din);
        int start;
        @(negedge clk);
        start           = cycle;
        wait_low_cycles = 0;
        cpu_addr        = a;
        cpu_dout        = d;
        cpu_mreq_n      = 1'b0;
        cpu_wr_n        = !w;
        cpu_rd_n        = !r;
        if (exp_hit && w) begin
            pushExp(K_WR, a[10:0], d, start + LAT_STB);
        end else if (exp_hit && r) begin
            pushExp(K_RD, a[10:0], 8'h00, start + LAT_STB);
            pushExp(K_DIN, 11'h000, exp_din, start + LAT_DIN);
        end
        repeat (hold - 1) @(negedge clk);
        if (exp_hit && r && !w) checkOutput("doe_held_until_mreq", int'(cpu_doe), 1);
        else                    checkOutput("doe_low_no_read", int'(cpu_doe), 0);
        @(negedge clk);
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_rd_n   = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("doe_cleared_after_mreq", int'(cpu_doe), 0);
        checkOutput("wait_low_cycles", wait_low_cycles, (exp_hit && r && !w) ? 2 : 0);
    endtask

    initial begin
        int start;
        checks          = 0;
        failures        = 0;
        cycle           = 0;
        wait_low_cycles = 0;
        doe_prev        = 1'b0;
        ram1_out        = 8'h00;
        resetn          = 1'b0;
        cpu_addr        = 16'h0000;
        cpu_dout        = 8'h00;
        cpu_mreq_n      = 1'b1;
        cpu_rd_n        = 1'b1;
        cpu_wr_n        = 1'b1;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] write 0x41 to 2805");
        applyStimulus(16'h2805, 1'b1, 1'b0, 8'h41, 40, 1'b1, 8'h00);
        checkOutput("addr_holds", int'(addr), 11'h005);
        checkOutput("data_holds", int'(data), 8'h41);

        $display("[TB] write 0x7F to 2FFF then read it back");
        applyStimulus(16'h2FFF, 1'b1, 1'b0, 8'h7F, 20, 1'b1, 8'h00);
        applyStimulus(16'h2FFF, 1'b0, 1'b1, 8'h00, 20, 1'b1, 8'h7F);
        checkOutput("din_holds_after_doe", int'(cpu_din), 8'h7F);

        $display("[TB] accesses outside the window");
        applyStimulus(16'h3000, 1'b1, 1'b0, 8'h55, 20, 1'b0, 8'h00);
        applyStimulus(16'h3000, 1'b0, 1'b1, 8'h00, 20, 1'b0, 8'h00);
        applyStimulus(16'h27FF, 1'b1, 1'b0, 8'hAA, 20, 1'b0, 8'h00);
        applyStimulus(16'h27FF, 1'b0, 1'b1, 8'h00, 20, 1'b0, 8'h00);
        checkOutput("miss_keeps_addr", int'(addr), 11'h7FF);

        $display("[TB] refresh cycle at 2800");
        applyStimulus(16'h2800, 1'b0, 1'b0, 8'h00, 20, 1'b0, 8'h00);

        $display("[TB] reset during a read");
        @(negedge clk);
        start      = cycle;
        cpu_addr   = 16'h2FFF;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        pushExp(K_RD, 11'h7FF, 8'h00, start + LAT_STB);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        resetn     = 1'b0;
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("midread_reset");
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_doe", int'(cpu_doe), 0);
        checkOutput("post_reset_wait_n", int'(cpu_wait_n), 1);

        $display("[TB] access after reset recovery");
        applyStimulus(16'h2ABC, 1'b1, 1'b0, 8'h3C, 20, 1'b1, 8'h00);
        applyStimulus(16'h2ABC, 1'b0, 1'b1, 8'h00, 20, 1'b1, 8'h3C);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
